// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch (IF) and
// data-memory (DM) requesters of the core. Each access is a registered
// request/ack handshake with variable-latency memory. A combinational
// stall flag freezes the core while one of its accesses is outstanding.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a BUSY access with no Mem_Ack_Arb for TIMEOUT_CYC cycles
//   is aborted. The requester then gets a Valid pulse with
//   RData = 32'hEEEEEEEE and Err_Arb high in the same cycle.
//   When undefined, BUSY waits indefinitely and Err_Arb is tied low.

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_Arb,
  input  logic              rst_Arb,
  input  logic              IF_Req_Arb,
  input  logic [ADDR_W-1:0] IF_Addr_Arb,
  output logic              IF_Valid_Arb,
  output logic [DATA_W-1:0] IF_RData_Arb,
  input  logic              DM_Req_Arb,
  input  logic              DM_We_Arb,
  input  logic [ADDR_W-1:0] DM_Addr_Arb,
  input  logic [DATA_W-1:0] DM_WData_Arb,
  output logic              DM_Valid_Arb,
  output logic [DATA_W-1:0] DM_RData_Arb,
  output logic              Mem_Req_Arb,
  output logic              Mem_We_Arb,
  output logic [ADDR_W-1:0] Mem_Addr_Arb,
  output logic [DATA_W-1:0] Mem_WData_Arb,
  input  logic [DATA_W-1:0] Mem_RData_Arb,
  input  logic              Mem_Ack_Arb,
  output logic              Stall_Arb,
  output logic              Err_Arb
);

  // The starvation counter is 4 bits wide, so STARVE_MAX must fit in 1..15.
  // The timeout counter needs at least two states to be meaningful.
  if ((STARVE_MAX < 1) || (STARVE_MAX > 15) || (TIMEOUT_CYC < 2)) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_MAX or TIMEOUT_CYC out of range");
  end

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  logic              mem_req_r,   mem_req_s;
  logic              mem_we_r,    mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              if_valid_r,  if_valid_s;
  logic              dm_valid_r,  dm_valid_s;
  logic [DATA_W-1:0] if_rdata_r,  if_rdata_s;
  logic [DATA_W-1:0] dm_rdata_r,  dm_rdata_s;
  logic [3:0]        starve_r,    starve_s;
  logic              grant_if_s;
  logic              grant_dm_s;

`ifdef ARB_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = {(DATA_W/4){4'hE}};

  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic             err_r, err_s;
`endif

  // Arbitration in IDLE: DM wins a tie unless IF has lost STARVE_MAX times in a row
  always_comb begin
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    starve_s   = starve_r;
    if (state_r == IDLE) begin
      if (IF_Req_Arb && DM_Req_Arb) begin
        if (starve_r == STARVE_LIM) begin
          grant_if_s = 1'b1;
          starve_s   = 4'd0;
        end else begin
          grant_dm_s = 1'b1;
          if (starve_r < STARVE_LIM) begin
            starve_s = starve_r + 4'd1;
          end else begin
            starve_s = starve_r;
          end
        end
      end else if (IF_Req_Arb) begin
        grant_if_s = 1'b1;
        starve_s   = 4'd0;
      end else if (DM_Req_Arb) begin
        grant_dm_s = 1'b1;
        starve_s   = starve_r;
      end else begin
        starve_s = starve_r;
      end
    end else begin
      starve_s = starve_r;
    end
  end

  // Next-state and next-register values for the access sequencer
  always_comb begin
    state_s     = state_r;
    mem_req_s   = mem_req_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_valid_s  = 1'b0;
    dm_valid_s  = 1'b0;
    if_rdata_s  = if_rdata_r;
    dm_rdata_s  = dm_rdata_r;
`ifdef ARB_TIMEOUT_EN
    tmo_s       = tmo_r;
    err_s       = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (grant_if_s) begin
          state_s     = BUSY_IF;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = IF_Addr_Arb;
          mem_wdata_s = {DATA_W{1'b0}};
`ifdef ARB_TIMEOUT_EN
          tmo_s       = {TMO_W{1'b0}};
`endif
        end else if (grant_dm_s) begin
          state_s     = BUSY_DM;
          mem_req_s   = 1'b1;
          mem_we_s    = DM_We_Arb;
          mem_addr_s  = DM_Addr_Arb;
          mem_wdata_s = DM_WData_Arb;
`ifdef ARB_TIMEOUT_EN
          tmo_s       = {TMO_W{1'b0}};
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (Mem_Ack_Arb) begin
          // An ack always wins, even in the cycle the timeout would fire.
          state_s   = RESP;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          if (state_r == BUSY_IF) begin
            if_valid_s = 1'b1;
            if_rdata_s = Mem_RData_Arb;
          end else begin
            dm_valid_s = 1'b1;
            // Stores return zero so the core never sees stale bus data.
            dm_rdata_s = mem_we_r ? {DATA_W{1'b0}} : Mem_RData_Arb;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_r == TMO_LAST) begin
          state_s   = RESP;
          mem_req_s = 1'b0;
          mem_we_s  = 1'b0;
          err_s     = 1'b1;
          if (state_r == BUSY_IF) begin
            if_valid_s = 1'b1;
            if_rdata_s = TMO_DATA;
          end else begin
            dm_valid_s = 1'b1;
            dm_rdata_s = TMO_DATA;
          end
        end else begin
          tmo_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_s = state_r;
        end
`endif
      end
      RESP: begin
        // One response cycle; no arbitration here, so a requester has time to drop Req.
        state_s = IDLE;
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_Arb or negedge rst_Arb) begin
    if (!rst_Arb) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered memory-side, response-side and starvation state
  always_ff @(posedge clk_Arb or negedge rst_Arb) begin
    if (!rst_Arb) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_valid_r  <= 1'b0;
      dm_valid_r  <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      starve_r    <= 4'd0;
    end else begin
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_valid_r  <= if_valid_s;
      dm_valid_r  <= dm_valid_s;
      if_rdata_r  <= if_rdata_s;
      dm_rdata_r  <= dm_rdata_s;
      starve_r    <= starve_s;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Timeout counter and error pulse
  always_ff @(posedge clk_Arb or negedge rst_Arb) begin
    if (!rst_Arb) begin
      tmo_r <= {TMO_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      tmo_r <= tmo_s;
      err_r <= err_s;
    end
  end

  assign Err_Arb = err_r;
`else
  assign Err_Arb = 1'b0;
`endif

  assign Mem_Req_Arb   = mem_req_r;
  assign Mem_We_Arb    = mem_we_r;
  assign Mem_Addr_Arb  = mem_addr_r;
  assign Mem_WData_Arb = mem_wdata_r;
  assign IF_Valid_Arb  = if_valid_r;
  assign DM_Valid_Arb  = dm_valid_r;
  assign IF_RData_Arb  = if_rdata_r;
  assign DM_RData_Arb  = dm_rdata_r;

  // The stall drops in the Valid cycle so the core can advance on that edge.
  assign Stall_Arb = (IF_Req_Arb & ~if_valid_r) | (DM_Req_Arb & ~dm_valid_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected completions are queued
// when a request is driven and popped when a Valid pulse appears.
module tb_mem_port_arbiter;

  logic        clk_Arb = 1'b0;
  logic        rst_Arb;
  logic        IF_Req_Arb;
  logic [31:0] IF_Addr_Arb;
  logic        IF_Valid_Arb;
  logic [31:0] IF_RData_Arb;
  logic        DM_Req_Arb;
  logic        DM_We_Arb;
  logic [31:0] DM_Addr_Arb;
  logic [31:0] DM_WData_Arb;
  logic        DM_Valid_Arb;
  logic [31:0] DM_RData_Arb;
  logic        Mem_Req_Arb;
  logic        Mem_We_Arb;
  logic [31:0] Mem_Addr_Arb;
  logic [31:0] Mem_WData_Arb;
  logic [31:0] Mem_RData_Arb;
  logic        Mem_Ack_Arb;
  logic        Stall_Arb;
  logic        Err_Arb;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk_Arb(clk_Arb), .rst_Arb(rst_Arb),
    .IF_Req_Arb(IF_Req_Arb), .IF_Addr_Arb(IF_Addr_Arb),
    .IF_Valid_Arb(IF_Valid_Arb), .IF_RData_Arb(IF_RData_Arb),
    .DM_Req_Arb(DM_Req_Arb), .DM_We_Arb(DM_We_Arb), .DM_Addr_Arb(DM_Addr_Arb),
    .DM_WData_Arb(DM_WData_Arb), .DM_Valid_Arb(DM_Valid_Arb), .DM_RData_Arb(DM_RData_Arb),
    .Mem_Req_Arb(Mem_Req_Arb), .Mem_We_Arb(Mem_We_Arb), .Mem_Addr_Arb(Mem_Addr_Arb),
    .Mem_WData_Arb(Mem_WData_Arb), .Mem_RData_Arb(Mem_RData_Arb), .Mem_Ack_Arb(Mem_Ack_Arb),
    .Stall_Arb(Stall_Arb), .Err_Arb(Err_Arb)
  );

  always #5 clk_Arb = ~clk_Arb;

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // memory model controls
  int mem_wait  = 0;
  bit mem_never = 1'b0;
  bit force_ack = 1'b0;
  int wait_cnt  = 0;

  localparam logic [31:0] IF_A = 32'h0000_1000;
  localparam logic [31:0] DM_A = 32'h0000_2000;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h8C08_0044;
  endfunction

  // Memory model: acks mem_wait cycles after the request appears
  always @(negedge clk_Arb) begin
    if (force_ack) begin
      Mem_Ack_Arb   = 1'b1;
      Mem_RData_Arb = 32'hDEAD_BEEF;
    end else if (Mem_Req_Arb && !Mem_Ack_Arb && !mem_never) begin
      if (wait_cnt >= mem_wait) begin
        Mem_Ack_Arb   = 1'b1;
        Mem_RData_Arb = rdata_of(Mem_Addr_Arb);
        wait_cnt      = 0;
      end else begin
        Mem_Ack_Arb = 1'b0;
        wait_cnt    = wait_cnt + 1;
      end
    end else begin
      Mem_Ack_Arb = 1'b0;
      if (!Mem_Req_Arb) wait_cnt = 0;
    end
  end

  // Pop the oldest expectation and compare it with the current Valid cycle
  task automatic sb_check_valid();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got if_valid=%0b dm_valid=%0b with no expected completion",
               IF_Valid_Arb, DM_Valid_Arb);
    end else begin
      e = sb_q.pop_front();
      if (e.is_dm) begin
        if (DM_Valid_Arb !== 1'b1 || IF_Valid_Arb !== 1'b0 || DM_RData_Arb !== e.rdata ||
            Err_Arb !== e.err) begin
          errors++;
          $display("FAIL sb_dm: got dm_v=%0b if_v=%0b rdata=%h err=%0b, expected dm_v=1 if_v=0 rdata=%h err=%0b",
                   DM_Valid_Arb, IF_Valid_Arb, DM_RData_Arb, Err_Arb, e.rdata, e.err);
        end
      end else begin
        if (IF_Valid_Arb !== 1'b1 || DM_Valid_Arb !== 1'b0 || IF_RData_Arb !== e.rdata ||
            Err_Arb !== e.err) begin
          errors++;
          $display("FAIL sb_if: got if_v=%0b dm_v=%0b rdata=%h err=%0b, expected if_v=1 dm_v=0 rdata=%h err=%0b",
                   IF_Valid_Arb, DM_Valid_Arb, IF_RData_Arb, Err_Arb, e.rdata, e.err);
        end
      end
    end
  endtask

  // Wait (bounded) for the next Valid pulse and score it
  task automatic wait_valid(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_Arb);
      if (IF_Valid_Arb || DM_Valid_Arb) begin
        sb_check_valid();
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no completion within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_Arb = 1'b0;
    IF_Req_Arb = 1'b0; IF_Addr_Arb = 32'h0;
    DM_Req_Arb = 1'b0; DM_We_Arb = 1'b0; DM_Addr_Arb = 32'h0; DM_WData_Arb = 32'h0;
    repeat (2) @(negedge clk_Arb);
    checks++;
    if ({Mem_Req_Arb, Mem_We_Arb, IF_Valid_Arb, DM_Valid_Arb, Err_Arb, Stall_Arb} !== 6'b0 ||
        IF_RData_Arb !== 32'h0 || DM_RData_Arb !== 32'h0 || Mem_Addr_Arb !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got req=%0b we=%0b ifv=%0b dmv=%0b err=%0b stall=%0b, expected all 0",
               Mem_Req_Arb, Mem_We_Arb, IF_Valid_Arb, DM_Valid_Arb, Err_Arb, Stall_Arb);
    end
    rst_Arb = 1'b1;
    // start a DM load that memory never answers, then reset mid-access
    mem_never = 1'b1;
    DM_Addr_Arb = DM_A; DM_Req_Arb = 1'b1;
    repeat (3) @(negedge clk_Arb);
    checks++;
    if (Mem_Req_Arb !== 1'b1 || Mem_Addr_Arb !== DM_A) begin
      errors++;
      $display("FAIL reset_busy_dm: got req=%0b addr=%h, expected req=1 addr=%h",
               Mem_Req_Arb, Mem_Addr_Arb, DM_A);
    end
    #2 rst_Arb = 1'b0;
    #1;
    checks++;
    if (Mem_Req_Arb !== 1'b0 || DM_Valid_Arb !== 1'b0 || Err_Arb !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got req=%0b dmv=%0b err=%0b, expected 0 0 0",
               Mem_Req_Arb, DM_Valid_Arb, Err_Arb);
    end
    DM_Req_Arb = 1'b0;
    mem_never  = 1'b0;
    @(negedge clk_Arb);
    rst_Arb = 1'b1;
    repeat (2) @(negedge clk_Arb);
    checks++;
    if (Mem_Req_Arb !== 1'b0 || IF_Valid_Arb !== 1'b0 || DM_Valid_Arb !== 1'b0 || Stall_Arb !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got req=%0b ifv=%0b dmv=%0b stall=%0b, expected all 0",
               Mem_Req_Arb, IF_Valid_Arb, DM_Valid_Arb, Stall_Arb);
    end
  endtask

  task automatic test_single_fetch();
    mem_wait = 0;
    IF_Addr_Arb = 32'h0000_0040; IF_Req_Arb = 1'b1;
    sb_q.push_back('{1'b0, 32'h8C08_0004, 1'b0});
    #1;
    checks++;
    if (Stall_Arb !== 1'b1 || Mem_Req_Arb !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0: got stall=%0b req=%0b, expected stall=1 req=0", Stall_Arb, Mem_Req_Arb);
    end
    @(negedge clk_Arb);
    checks++;
    if (Mem_Req_Arb !== 1'b1 || Mem_Addr_Arb !== 32'h40 || Mem_We_Arb !== 1'b0 ||
        Stall_Arb !== 1'b1 || IF_Valid_Arb !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c1: got req=%0b addr=%h we=%0b stall=%0b ifv=%0b, expected 1 00000040 0 1 0",
               Mem_Req_Arb, Mem_Addr_Arb, Mem_We_Arb, Stall_Arb, IF_Valid_Arb);
    end
    @(negedge clk_Arb);
    checks++;
    if (IF_Valid_Arb !== 1'b1 || Stall_Arb !== 1'b0 || Mem_Req_Arb !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c2: got ifv=%0b stall=%0b req=%0b, expected 1 0 0",
               IF_Valid_Arb, Stall_Arb, Mem_Req_Arb);
    end
    if (IF_Valid_Arb === 1'b1) sb_check_valid();
    IF_Req_Arb = 1'b0;
    @(negedge clk_Arb);
    checks++;
    if (IF_Valid_Arb !== 1'b0 || Mem_Req_Arb !== 1'b0 || IF_RData_Arb !== 32'h8C08_0004) begin
      errors++;
      $display("FAIL fetch_c3: got ifv=%0b req=%0b rdata=%h, expected 0 0 8c080004",
               IF_Valid_Arb, Mem_Req_Arb, IF_RData_Arb);
    end
  endtask

  task automatic test_store();
    int  busy   = 0;
    int  pulses = 0;
    bit  done   = 1'b0;
    mem_wait = 3;
    DM_We_Arb = 1'b1; DM_Addr_Arb = 32'h100; DM_WData_Arb = 32'h1234_5678; DM_Req_Arb = 1'b1;
    sb_q.push_back('{1'b1, 32'h0, 1'b0});
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_Arb);
      if (Mem_Req_Arb === 1'b1) begin
        busy++;
        checks++;
        if (Mem_We_Arb !== 1'b1 || Mem_WData_Arb !== 32'h1234_5678 || Mem_Addr_Arb !== 32'h100) begin
          errors++;
          $display("FAIL store_hold: got we=%0b wdata=%h addr=%h, expected 1 12345678 00000100",
                   Mem_We_Arb, Mem_WData_Arb, Mem_Addr_Arb);
        end
      end
      if (IF_Valid_Arb || DM_Valid_Arb) begin
        sb_check_valid();
        done = 1'b1;
      end
    end
    DM_Req_Arb = 1'b0; DM_We_Arb = 1'b0;
    checks++;
    if (!done || busy != 4) begin
      errors++;
      $display("FAIL store_busy: got done=%0b busy_cycles=%0d, expected done=1 busy_cycles=4", done, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_Arb);
      if (DM_Valid_Arb === 1'b1 || Mem_We_Arb === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || DM_RData_Arb !== 32'h0) begin
      errors++;
      $display("FAIL store_after: got extra_pulses=%0d rdata=%h, expected 0 00000000", pulses, DM_RData_Arb);
    end
    mem_wait = 0;
  endtask

  task automatic test_contention();
    int n = 0;
    mem_wait = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) sb_q.push_back('{1'b0, rdata_of(IF_A), 1'b0});
      else                  sb_q.push_back('{1'b1, rdata_of(DM_A), 1'b0});
    end
    IF_Addr_Arb = IF_A; IF_Req_Arb = 1'b1;
    DM_Addr_Arb = DM_A; DM_We_Arb = 1'b0; DM_Req_Arb = 1'b1;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk_Arb);
      if (IF_Valid_Arb || DM_Valid_Arb) begin
        checks++;
        if (Mem_Req_Arb !== 1'b0 || Stall_Arb !== 1'b1 || (IF_Valid_Arb && DM_Valid_Arb)) begin
          errors++;
          $display("FAIL contend_overlap: got req=%0b stall=%0b ifv=%0b dmv=%0b, expected req=0 stall=1 one valid",
                   Mem_Req_Arb, Stall_Arb, IF_Valid_Arb, DM_Valid_Arb);
        end
        sb_check_valid();
        n++;
        if (n == 10) begin
          IF_Req_Arb = 1'b0; DM_Req_Arb = 1'b0;
        end
      end
    end
    IF_Req_Arb = 1'b0; DM_Req_Arb = 1'b0;
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL contend_count: got %0d completions, expected 10", n);
    end
    @(negedge clk_Arb);
    mem_wait = 0;
  endtask

  task automatic test_ack_idle();
    int bad = 0;
    force_ack = 1'b1;
    @(negedge clk_Arb);
    force_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_Arb);
      if (IF_Valid_Arb !== 1'b0 || DM_Valid_Arb !== 1'b0 || Mem_Req_Arb !== 1'b0 ||
          IF_RData_Arb !== rdata_of(IF_A) || DM_RData_Arb !== rdata_of(DM_A)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ack_idle: got %0d disturbed cycles (ifrd=%h dmrd=%h), expected 0 (ifrd=%h dmrd=%h)",
               bad, IF_RData_Arb, DM_RData_Arb, rdata_of(IF_A), rdata_of(DM_A));
    end
    // still in IDLE: a new load is granted on the next edge
    DM_Addr_Arb = 32'h0000_2040; DM_We_Arb = 1'b0; DM_Req_Arb = 1'b1;
    sb_q.push_back('{1'b1, rdata_of(32'h0000_2040), 1'b0});
    @(negedge clk_Arb);
    checks++;
    if (Mem_Req_Arb !== 1'b1 || Mem_Addr_Arb !== 32'h0000_2040) begin
      errors++;
      $display("FAIL ack_idle_grant: got req=%0b addr=%h, expected 1 00002040", Mem_Req_Arb, Mem_Addr_Arb);
    end
    wait_valid(5);
    DM_Req_Arb = 1'b0;
    @(negedge clk_Arb);
  endtask

  task automatic test_timeout();
    mem_never = 1'b1;
    IF_Addr_Arb = 32'h0000_1080; IF_Req_Arb = 1'b1;
`ifdef ARB_TIMEOUT_EN
    begin
      int busy = 0;
      bit done = 1'b0;
      sb_q.push_back('{1'b0, 32'hEEEE_EEEE, 1'b1});
      for (int i = 0; i < 40 && !done; i++) begin
        @(negedge clk_Arb);
        if (Mem_Req_Arb === 1'b1) busy++;
        if (IF_Valid_Arb || DM_Valid_Arb) begin
          sb_check_valid();
          done = 1'b1;
        end
      end
      IF_Req_Arb = 1'b0;
      mem_never  = 1'b0;
      checks++;
      if (!done || busy != 16) begin
        errors++;
        $display("FAIL timeout_len: got done=%0b busy_cycles=%0d, expected done=1 busy_cycles=16", done, busy);
      end
      @(negedge clk_Arb);
      checks++;
      if (Err_Arb !== 1'b0 || IF_Valid_Arb !== 1'b0) begin
        errors++;
        $display("FAIL timeout_after: got err=%0b ifv=%0b, expected 0 0", Err_Arb, IF_Valid_Arb);
      end
    end
`else
    begin
      int bad = 0;
      sb_q.push_back('{1'b0, rdata_of(32'h0000_1080), 1'b0});
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_Arb);
        if (i > 0 && (Mem_Req_Arb !== 1'b1 || IF_Valid_Arb !== 1'b0 || Err_Arb !== 1'b0 ||
                      Stall_Arb !== 1'b1)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL no_timeout: got %0d cycles not pending, expected 0", bad);
      end
      mem_never = 1'b0;
      wait_valid(5);
      IF_Req_Arb = 1'b0;
      @(negedge clk_Arb);
    end
`endif
  endtask

  initial begin
    Mem_Ack_Arb   = 1'b0;
    Mem_RData_Arb = 32'h0;
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_ack_idle();
    test_timeout();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expectations, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
